// File: rtl/batmon_seq.sv
// Measurement sequencer for the charger monitor path: round-robins the enabled
// V/I/T channels through a shared 8-bit ADC and holds the latest codes.
module batmon_seq #(
  parameter int SETTLE  = 4,
  parameter int ADC_TMO = 64
) (
  input  logic       clk,
  input  logic       rst,
  inout  wire        dvdd,
  inout  wire        dgnd,
  input  logic       en,
  input  logic       vmonen,
  input  logic       imonen,
  input  logic       tmonen,
  output logic       adc_start,
  output logic [1:0] adc_sel,
  input  logic       adc_done,
  input  logic [7:0] adc_data,
  output logic [7:0] vbat,
  output logic [7:0] ibat,
  output logic [7:0] tbat,
  output logic       vtok
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CONV
  } state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);
  localparam logic [7:0] TMO_LAST    = 8'(ADC_TMO);

  state_t     state, state_d;
  logic [7:0] cnt, cnt_d;
  logic [1:0] sel_d;
  logic [1:0] last, last_d;
  logic       start_d;
  logic [3:0] valid, valid_d;
  logic [7:0] vbat_d, ibat_d, tbat_d;
  logic       vtok_d;
  logic       adv;

  logic [3:0] chen;
  logic       any_en;
  logic [2:0] first_pick;
  logic [2:0] next_pick;

  // Supply pins carry no logic; fold them into a sink so they read as used.
  wire unused_supply = &{1'b0, dvdd, dgnd};

  // Bit 3 pads the channel vector so a 2-bit select can index it directly.
  assign chen   = {1'b0, tmonen, imonen, vmonen};
  assign any_en = |chen;

  // Returns {found, channel}: first enabled channel strictly after cur in
  // V -> I -> T -> V order, wrapping back to cur itself last.
  function automatic logic [2:0] pick_after(input logic [1:0] cur,
                                            input logic [3:0] ena);
    logic [2:0] res;
    logic [1:0] c;
    res = 3'b000;
    for (int k = 3; k >= 1; k--) begin
      c = 2'((int'(cur) + k) % 3);
      if (ena[c]) res = {1'b1, c};
    end
    return res;
  endfunction

  assign first_pick = pick_after(last, chen);
  assign next_pick  = pick_after(adc_sel, chen);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the case below can leave one unassigned and infer a latch.
    state_d = state;
    cnt_d   = cnt;
    sel_d   = adc_sel;
    last_d  = last;
    start_d = 1'b0;
    vbat_d  = vbat;
    ibat_d  = ibat;
    tbat_d  = tbat;
    adv     = 1'b0;
    valid_d = en ? (valid & chen) : 4'b0000;

    case (state)
      S_IDLE: begin
        if (en && any_en) begin
          state_d = S_SETTLE;
          sel_d   = first_pick[1:0];
          cnt_d   = '0;
        end
      end
      S_SETTLE: begin
        if (!en) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (!chen[adc_sel]) begin
          adv = 1'b1;
        end else if (cnt == SETTLE_LAST) begin
          state_d = S_CONV;
          start_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end
      S_CONV: begin
        if (!en) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (!chen[adc_sel]) begin
          adv = 1'b1;
        end else if (adc_start) begin
          // A done pulse in the start cycle is too early to be ours.
          cnt_d = 8'd1;
        end else if (adc_done) begin
          case (adc_sel)
            2'd0:    vbat_d = adc_data;
            2'd1:    ibat_d = adc_data;
            2'd2:    tbat_d = adc_data;
            default: ;
          endcase
          valid_d[adc_sel] = 1'b1;
          adv              = 1'b1;
        end else if (cnt == TMO_LAST) begin
          valid_d[adc_sel] = 1'b0;
          adv              = 1'b1;
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (adv) begin
      last_d = adc_sel;
      cnt_d  = '0;
      if (next_pick[2]) begin
        state_d = S_SETTLE;
        sel_d   = next_pick[1:0];
      end else begin
        state_d = S_IDLE;
      end
    end

    vtok_d = en & any_en & (&(valid[2:0] | ~chen[2:0]));
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before this edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      adc_sel   <= 2'd0;
      last      <= 2'd2;
      adc_start <= 1'b0;
      valid     <= 4'b0000;
      vbat      <= 8'h00;
      ibat      <= 8'h00;
      tbat      <= 8'h00;
      vtok      <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      adc_sel   <= sel_d;
      last      <= last_d;
      adc_start <= start_d;
      valid     <= valid_d;
      vbat      <= vbat_d;
      ibat      <= ibat_d;
      tbat      <= tbat_d;
      vtok      <= vtok_d;
    end
  end

endmodule

// File: tb/tb_batmon_seq.sv
// Self-checking bench for batmon_seq: directed conversion table plus
// hand-written reset, abort and reset-mid-conversion sequences.
module tb_batmon_seq;

  localparam int TMO = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, vmonen, imonen, tmonen;
  logic       adc_done = 1'b0;
  logic [7:0] adc_data = 8'h00;
  logic       adc_start;
  logic [1:0] adc_sel;
  logic [7:0] vbat, ibat, tbat;
  logic       vtok;
  wire        dvdd, dgnd;

  assign dvdd = 1'b1;
  assign dgnd = 1'b0;

  batmon_seq #(.SETTLE(4), .ADC_TMO(TMO)) dut (
    .clk(clk), .rst(rst), .dvdd(dvdd), .dgnd(dgnd), .en(en),
    .vmonen(vmonen), .imonen(imonen), .tmonen(tmonen),
    .adc_start(adc_start), .adc_sel(adc_sel), .adc_done(adc_done),
    .adc_data(adc_data), .vbat(vbat), .ibat(ibat), .tbat(tbat), .vtok(vtok)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  // ADC model controls: latency 0 means the ADC never answers.
  int         lat_cur = 0;
  logic [7:0] data_cur = 8'h00;
  bit         stray_req = 1'b0;

  typedef struct {
    logic [2:0] ena;   // {t, i, v}
    int         lat;
    logic [7:0] data;
    logic [1:0] sel;
    logic       pre;   // vtok one cycle after enables are applied
    logic [7:0] v, i, t;
    logic       ok;    // vtok one cycle after the conversion ends
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic goto_edge(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  task automatic wait_start(input string name);
    for (int k = 0; k < 300; k++) begin
      if (adc_start === 1'b1) break;
      @(negedge clk);
    end
    check(name, 32'(adc_start), 32'd1);
  endtask

  // ADC model: start seen before edge s, done sampled at edge s+lat.
  initial begin
    bit         pending;
    int         left;
    logic [7:0] pdata;
    pending = 1'b0;
    left    = 0;
    pdata   = 8'h00;
    forever begin
      @(negedge clk);
      adc_done = 1'b0;
      if (pending) begin
        left--;
        if (left == 0) begin
          adc_done = 1'b1;
          adc_data = pdata;
          pending  = 1'b0;
        end
      end
      if (adc_start === 1'b1 && lat_cur > 0) begin
        pending = 1'b1;
        left    = lat_cur;
        pdata   = data_cur;
      end
      if (stray_req) begin
        adc_done  = 1'b1;
        adc_data  = 8'hEE;
        stray_req = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int e0, s, end_e, starts;

    tbl[0]  = '{3'b111, 2,   8'hC8, 2'd0, 1'b0, 8'hC8, 8'h00, 8'h00, 1'b0};
    tbl[1]  = '{3'b111, 5,   8'h66, 2'd1, 1'b0, 8'hC8, 8'h66, 8'h00, 1'b0};
    tbl[2]  = '{3'b111, 1,   8'h64, 2'd2, 1'b0, 8'hC8, 8'h66, 8'h64, 1'b1};
    tbl[3]  = '{3'b111, 3,   8'h11, 2'd0, 1'b1, 8'h11, 8'h66, 8'h64, 1'b1};
    tbl[4]  = '{3'b111, 0,   8'h00, 2'd1, 1'b1, 8'h11, 8'h66, 8'h64, 1'b0};
    tbl[5]  = '{3'b111, 4,   8'h77, 2'd2, 1'b0, 8'h11, 8'h66, 8'h77, 1'b0};
    tbl[6]  = '{3'b111, 2,   8'h22, 2'd0, 1'b0, 8'h22, 8'h66, 8'h77, 1'b0};
    tbl[7]  = '{3'b111, TMO, 8'h5A, 2'd1, 1'b0, 8'h22, 8'h5A, 8'h77, 1'b1};
    tbl[8]  = '{3'b001, 1,   8'h33, 2'd0, 1'b1, 8'h33, 8'h5A, 8'h77, 1'b1};
    tbl[9]  = '{3'b101, 2,   8'h44, 2'd0, 1'b0, 8'h44, 8'h5A, 8'h77, 1'b0};
    tbl[10] = '{3'b101, 3,   8'h99, 2'd2, 1'b0, 8'h44, 8'h5A, 8'h99, 1'b1};

    rst = 1'b1; en = 1'b0; vmonen = 1'b0; imonen = 1'b0; tmonen = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_start", 32'(adc_start), 32'd0);
    check("rst_sel",   32'(adc_sel),   32'd0);
    check("rst_res",   32'({vbat, ibat, tbat}), 32'd0);
    check("rst_vtok",  32'(vtok),      32'd0);
    rst = 1'b0;

    // Single channel from reset: V only, L=3, code 0xA4.
    @(negedge clk);
    lat_cur = 3; data_cur = 8'hA4;
    en = 1'b1; vmonen = 1'b1;
    e0 = cyc + 1;
    goto_edge(e0 + 3);  check("t1_start_early", 32'(adc_start), 32'd0);
    goto_edge(e0 + 4);  check("t1_start",       32'(adc_start), 32'd1);
                        check("t1_sel",         32'(adc_sel),   32'd0);
    goto_edge(e0 + 7);  check("t1_vbat_early",  32'(vbat),      32'h00);
    goto_edge(e0 + 8);  check("t1_vbat",        32'(vbat),      32'hA4);
                        check("t1_vtok_early",  32'(vtok),      32'd0);
    goto_edge(e0 + 9);  check("t1_vtok",        32'(vtok),      32'd1);
    goto_edge(e0 + 11); check("t1_restart_early", 32'(adc_start), 32'd0);
    goto_edge(e0 + 12); check("t1_restart",     32'(adc_start), 32'd1);

    en = 1'b0; vmonen = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;

    // Conversion table: each record is one conversion.
    for (int r = 0; r < 11; r++) begin
      {tmonen, imonen, vmonen} = tbl[r].ena;
      lat_cur  = tbl[r].lat;
      data_cur = tbl[r].data;
      @(negedge clk);
      check($sformatf("v%0d_pre_vtok", r), 32'(vtok), 32'(tbl[r].pre));
      wait_start($sformatf("v%0d_start", r));
      s = cyc + 1;
      check($sformatf("v%0d_sel", r), 32'(adc_sel), 32'(tbl[r].sel));
      end_e = s + ((tbl[r].lat == 0) ? TMO : tbl[r].lat);
      goto_edge(end_e);
      check($sformatf("v%0d_vbat", r), 32'(vbat), 32'(tbl[r].v));
      check($sformatf("v%0d_ibat", r), 32'(ibat), 32'(tbl[r].i));
      check($sformatf("v%0d_tbat", r), 32'(tbat), 32'(tbl[r].t));
      goto_edge(end_e + 1);
      check($sformatf("v%0d_vtok", r), 32'(vtok), 32'(tbl[r].ok));
    end

    // Abort: drop en mid-CONV, then inject a stray done.
    lat_cur = 10; data_cur = 8'hEE;
    wait_start("ab_start");
    check("ab_sel", 32'(adc_sel), 32'd0);
    repeat (2) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("ab_vtok", 32'(vtok), 32'd0);
    check("ab_res",  32'({vbat, ibat, tbat}), 32'h445A99);
    stray_req = 1'b1;
    starts = 0;
    repeat (20) begin
      @(negedge clk);
      if (adc_start === 1'b1) starts++;
    end
    check("ab_no_start", 32'(starts), 32'd0);
    check("ab_res_kept", 32'({vbat, ibat, tbat}), 32'h445A99);
    check("ab_vtok_kept", 32'(vtok), 32'd0);
    en = 1'b1;
    e0 = cyc + 1;
    goto_edge(e0 + 3); check("ab_restart_early", 32'(adc_start), 32'd0);
    goto_edge(e0 + 4); check("ab_restart",       32'(adc_start), 32'd1);
                       check("ab_restart_sel",   32'(adc_sel),   32'd0);
                       check("ab_restart_vtok",  32'(vtok),      32'd0);

    // Reset in the middle of a conversion; the late done must be ignored.
    repeat (2) @(negedge clk);
    rst = 1'b1; en = 1'b0;
    @(negedge clk);
    check("rm_res",   32'({vbat, ibat, tbat}), 32'd0);
    check("rm_vtok",  32'(vtok),      32'd0);
    check("rm_sel",   32'(adc_sel),   32'd0);
    check("rm_start", 32'(adc_start), 32'd0);
    rst = 1'b0;
    starts = 0;
    repeat (15) begin
      @(negedge clk);
      if (adc_start === 1'b1) starts++;
    end
    check("rm_no_start", 32'(starts), 32'd0);
    check("rm_res_kept", 32'({vbat, ibat, tbat}), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
